lcd_pixel_sink: RTL
===================

# lcd_pixel_sink

Consumer end of the PPU pixel stream. Accepts the 2-bit background pixel codes and valid strobe produced during DRAW, maps them through the BGP palette, and packs four shades per byte. Writes each completed byte into a 160x144 2bpp framebuffer through a small FIFO with a valid/ready write handshake. Tracks line and frame position from the PPU mode so the display side never needs PPU internals.

## Interface
- FIFO_DEPTH, 4: byte entries buffered toward the framebuffer (power of two, ≥2)
- LINE_PIXELS, 160: visible pixels per line
- LINES, 144: visible lines per frame
- FB_BASE, 13'h0000: framebuffer byte address of pixel (0,0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- lcd_en  in  1  LCDC[7]; low = synchronous clear of all state except reset-only items
- ppu_mode  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- px_in  in  2  background colour index
- px_valid  in  1  px_in valid this cycle
- bgp  in  8  palette; shade(i) = bgp[2i+1:2i]
- fb_we  out  1  write request (FIFO non-empty)
- fb_addr  out  13  framebuffer byte address
- fb_data  out  8  four shades, earliest pixel in [7:6]
- fb_ready  in  1  framebuffer accepts write this cycle
- line_done  out  1  one-cycle pulse at end of each visible line
- frame_done  out  1  one-cycle pulse on entry to V_BLANK
- overflow  out  1  sticky: pixel byte dropped because FIFO full
- cur_line  out  8  current line index 0..143

## Operation
- Counters: x (0..LINE_PIXELS), line (0..LINES), pack count (0..3), pack shift register (8 bits).
- Accepted pixel: px_valid=1, ppu_mode=DRAW, lcd_en=1, x<LINE_PIXELS, line<LINES. Other px_valid pulses ignored (no counter change).
- Accepted pixel: shade = bgp[2*px_in+1 -: 2] using bgp sampled the same cycle; shifted into pack reg from the right; x+1, pack count+1.
- Fourth pixel of a group: byte {p0,p1,p2,p3} pushed to FIFO with address FB_BASE + line*40 + (x>>2) (x before increment); pack count→0.
- Line end: ppu_mode leaves DRAW (registered previous mode = DRAW, current ≠ DRAW). If pack count≠0, partial byte pushed left-justified, unused low bits 0. Then x→0, pack count→0, line+1 (saturates at LINES), line_done pulses if line was <LINES.
- Frame end: ppu_mode enters V_BLANK from any other mode → line→0, x→0, frame_done pulse. Entering V_BLANK directly from DRAW performs the line-end flush first (same cycle push), then line→0.
- FIFO: head drives fb_addr/fb_data; fb_we = not empty. Pop when fb_we && fb_ready. Push when byte complete and (not full, or pop same cycle). Push while full without pop: byte dropped, overflow←1.
- overflow cleared only by rst_n or lcd_en=0.
- lcd_en=0: FIFO emptied, all counters 0, fb_we=0, pulses 0, overflow 0, pixels ignored.
- Arithmetic: line*40 computed as (line<<5)+(line<<3), 13 bits, no overflow for line≤143; FB_BASE add wraps modulo 2^13.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, line_done=0, frame_done=0, overflow=0, cur_line=0; FIFO empty, all counters 0.
- Latency: 4th accepted pixel at cycle N → fb_we=1 with that byte at N+1 when FIFO was empty.
- fb_addr/fb_data held stable while fb_we=1 and fb_ready=0.
- Full throughput: 1 byte/4 pixels sustained with fb_ready=1; FIFO absorbs up to FIFO_DEPTH bytes of stall.
- line_done/frame_done asserted the cycle after the mode transition is seen; cur_line updates same edge.
- Pixel accepted on the same cycle mode leaves DRAW is not accepted (mode≠DRAW).
- rst_n assertion mid-write: all outputs to reset values immediately (asynchronous); pending FIFO data discarded.

## Test plan
- Line of 160 pixels px_in=0,1,2,3 repeating, bgp=8'hE4, fb_ready=1 → 40 writes, addr 0..39, every fb_data=8'h1B, one line_done, cur_line 0→1.
- Same line with bgp=8'h1B → all fb_data=8'hE4; bgp=8'h00 → all 8'h00.
- DRAW ends after 6 pixels all px_in=3, bgp=8'hE4, line 2 → writes addr 80 data 8'hFF, then addr 81 data 8'hF0; x resets.
- fb_ready=0 for 6 byte times, FIFO_DEPTH=4 → first 4 bytes retained in order, 5th/6th dropped, overflow=1 sticky; fb_ready=1 drains 4 writes; lcd_en pulse low clears overflow.
- 144 lines then V_BLANK → frame_done one pulse, cur_line=0; 145th-line pixels in DRAW before V_BLANK produce no writes.
- rst_n low while fb_we=1 and 3 bytes queued → fb_we=0 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/lcd_pixel_sink.sv
// rtl/lcd_pixel_sink.sv - PPU background pixel sink: palette map, 2bpp packing, framebuffer write FIFO.
module lcd_pixel_sink #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          LINE_PIXELS = 160,
    parameter int          LINES       = 144,
    parameter logic [12:0] FB_BASE     = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    input  logic [7:0]  bgp,
    output logic        fb_we,
    output logic [12:0] fb_addr,
    output logic [7:0]  fb_data,
    input  logic        fb_ready,
    output logic        line_done,
    output logic        frame_done,
    output logic        overflow,
    output logic [7:0]  cur_line
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [1:0]  M_VBLANK = 2'd1;
    localparam logic [1:0]  M_DRAW   = 2'd3;

    logic [7:0]  x_q, x_d;
    logic [7:0]  line_q, line_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  pack_q, pack_d;
    logic [1:0]  mode_q;
    logic        line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d;
    logic        overflow_q, overflow_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [20:0] mem [FIFO_DEPTH];

    logic        accept, line_end, vblank_entry;
    logic [1:0]  shade;
    logic [7:0]  pack_next;
    logic [12:0] line_x40, byte_addr;
    logic [2:0]  pad_shift;
    logic        push_req, push, pop, empty, full;
    logic [7:0]  push_data;

    always_comb begin
        shade        = bgp[{px_in, 1'b0} +: 2];
        pack_next    = {pack_q[5:0], shade};
        accept       = lcd_en && px_valid && (ppu_mode == M_DRAW)
                       && (x_q < 8'(LINE_PIXELS)) && (line_q < 8'(LINES));
        line_end     = lcd_en && (mode_q == M_DRAW) && (ppu_mode != M_DRAW);
        vblank_entry = lcd_en && (ppu_mode == M_VBLANK) && (mode_q != M_VBLANK);
        line_x40     = ({5'd0, line_q} << 5) + ({5'd0, line_q} << 3);
        byte_addr    = FB_BASE + line_x40 + {7'd0, x_q[7:2]};
        // Partial byte is left-justified: shift by 2*(4-count) bits.
        pad_shift    = {2'd0 - cnt_q, 1'b0};

        push_req  = 1'b0;
        push_data = 8'd0;
        if (accept && cnt_q == 2'd3) begin
            push_req  = 1'b1;
            push_data = pack_next;
        end else if (line_end && cnt_q != 2'd0) begin
            push_req  = 1'b1;
            push_data = pack_q << pad_shift;
        end

        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW] != rd_ptr_q[PW])
                && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        pop   = !empty && fb_ready;
        push  = push_req && (!full || pop);
    end

    always_comb begin
        x_d          = x_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q || (push_req && !push);
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        if (accept) begin
            x_d    = x_q + 8'd1;
            cnt_d  = cnt_q + 2'd1;
            pack_d = pack_next;
        end
        if (line_end) begin
            x_d    = 8'd0;
            cnt_d  = 2'd0;
            pack_d = 8'd0;
            if (line_q < 8'(LINES)) begin
                line_d      = line_q + 8'd1;
                line_done_d = 1'b1;
            end
        end
        // Frame restart wins over the line increment when DRAW exits straight into V_BLANK.
        if (vblank_entry) begin
            line_d       = 8'd0;
            x_d          = 8'd0;
            cnt_d        = 2'd0;
            pack_d       = 8'd0;
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            pack_q       <= '0;
            mode_q       <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else if (!lcd_en) begin
            x_q          <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            pack_q       <= '0;
            mode_q       <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            x_q          <= x_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            mode_q       <= ppu_mode;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PW-1:0]] <= {byte_addr, push_data};
        end
    end

    // Head is masked while empty so the outputs read zero out of reset and after a clear.
    always_comb begin
        fb_we = !empty;
        {fb_addr, fb_data} = empty ? 21'd0 : mem[rd_ptr_q[PW-1:0]];
    end

    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign cur_line   = line_q;

endmodule
